// File: rtl/writeback_arbiter_pkg.sv
// Shared types for the writeback path: ROB-renamed destination, exception codes,
// and the writeback entry carried from execution units to the reorder buffer.
package writeback_arbiter_pkg;

    localparam int unsigned DataWidth    = 32;
    localparam int unsigned RobIdWidth   = 6;
    localparam int unsigned ExpCodeWidth = 4;

    // Control strobes on this path are active-low.
    localparam logic Enable_  = 1'b0;
    localparam logic Disable_ = 1'b1;

    typedef struct packed {
        logic [RobIdWidth-1:0] addr;
    } RegFile_t;

    typedef enum logic [ExpCodeWidth-1:0] {
        EXP_I_MISS_ALIGN = 4'h0,
        EXP_I_ACCESS     = 4'h1,
        EXP_ILLEGAL_INST = 4'h2,
        EXP_BREAK        = 4'h3,
        EXP_D_MISS_ALIGN = 4'h4,
        EXP_D_ACCESS     = 4'h5,
        EXP_ECALL        = 4'h8
    } ExpCode_t;

    typedef struct packed {
        RegFile_t              rd;
        logic [DataWidth-1:0]  data;
        logic                  exp_;
        ExpCode_t              exp_code;
        logic                  pred_miss_;
        logic                  jump_miss_;
    } WbEntry_t;

    localparam WbEntry_t WbEntryReset = '{
        rd:         '0,
        data:       '0,
        exp_:       Disable_,
        exp_code:   EXP_I_MISS_ALIGN,
        pred_miss_: Disable_,
        jump_miss_: Disable_
    };

endpackage

// File: rtl/writeback_arbiter_wb_fifo.sv
// Small circular-buffer FIFO holding completed results from one execution unit.
// Pushes into a full FIFO and pops from an empty one are ignored.
module wb_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type entry_t = WbEntry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  logic   pop,
    input  logic   clear,
    input  entry_t din,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int unsigned PtrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntWidth = $clog2(DEPTH + 1);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(DEPTH - 1);

    entry_t              mem [DEPTH];
    logic [PtrWidth-1:0] head_ptr;
    logic [PtrWidth-1:0] tail_ptr;
    logic [CntWidth-1:0] count;
    logic                do_push;
    logic                do_pop;

    assign full    = (count == CntWidth'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[head_ptr];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) tail_ptr <= (tail_ptr == LastPtr) ? '0 : tail_ptr + 1'b1;
            if (do_pop)  head_ptr <= (head_ptr == LastPtr) ? '0 : head_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[tail_ptr] <= din;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Serializes results from SRC execution units onto the single ROB writeback port
// through per-source FIFOs and a round-robin arbiter draining one entry per cycle.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned DATA  = DataWidth,
    parameter int unsigned SRC   = 3,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_,
    input  logic [SRC-1:0]           src_e_,
    input  RegFile_t [SRC-1:0]       src_rd,
    input  logic [SRC-1:0][DATA-1:0] src_data,
    input  logic [SRC-1:0]           src_exp_,
    input  ExpCode_t [SRC-1:0]       src_exp_code,
    input  logic [SRC-1:0]           src_pred_miss_,
    input  logic [SRC-1:0]           src_jump_miss_,
    output logic [SRC-1:0]           src_full,
    output logic                     wb_e_,
    output RegFile_t                 wb_rd,
    output logic [DATA-1:0]          wb_data,
    output logic                     wb_exp_,
    output ExpCode_t                 wb_exp_code,
    output logic                     wb_pred_miss_,
    output logic                     wb_jump_miss_,
    output logic                     overflow
);

    localparam int unsigned PtrWidth = (SRC > 1) ? $clog2(SRC) : 1;
    localparam logic [PtrWidth-1:0] LastSrc = PtrWidth'(SRC - 1);

    WbEntry_t [SRC-1:0]  src_entry;
    WbEntry_t            head [SRC];
    logic [SRC-1:0]      valid_in;
    logic [SRC-1:0]      push;
    logic [SRC-1:0]      pop;
    logic [SRC-1:0]      empty;
    logic [SRC-1:0]      full;
    logic                flush;
    logic [PtrWidth-1:0] rr_ptr;
    logic [PtrWidth-1:0] grant_idx;
    logic                grant_valid;
    logic                wb_e_q;
    WbEntry_t            wb_q;

    assign flush = (flush_ == Enable_);

    always_comb begin
        for (int unsigned i = 0; i < SRC; i++) begin
            valid_in[i]  = (src_e_[i] == Enable_);
            src_entry[i] = '{
                rd:         src_rd[i],
                data:       DataWidth'(src_data[i]),
                exp_:       src_exp_[i],
                exp_code:   src_exp_code[i],
                pred_miss_: src_pred_miss_[i],
                jump_miss_: src_jump_miss_[i]
            };
        end
    end

    // A flush discards the whole cycle: no pushes, no pops.
    assign push = valid_in & ~{SRC{flush}};

    for (genvar i = 0; i < SRC; i++) begin : g_src
        assign pop[i] = grant_valid && !flush && (grant_idx == PtrWidth'(i));

        wb_fifo #(
            .DEPTH   (DEPTH),
            .entry_t (WbEntry_t)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[i]),
            .pop   (pop[i]),
            .clear (flush),
            .din   (src_entry[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .head  (head[i])
        );
    end

    assign src_full = full;

    // First non-empty FIFO searching upward from rr_ptr, wrapping mod SRC.
    always_comb begin
        int unsigned         idx;
        logic [PtrWidth-1:0] cand;
        grant_valid = 1'b0;
        grant_idx   = rr_ptr;
        idx         = 0;
        cand        = '0;
        for (int unsigned k = 0; k < SRC; k++) begin
            idx  = (32'(rr_ptr) + k) % SRC;
            cand = PtrWidth'(idx);
            if (!grant_valid && !empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_e_q   <= Disable_;
            wb_q     <= WbEntryReset;
            rr_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (!flush && |(valid_in & full)) overflow <= 1'b1;
            if (flush) begin
                wb_e_q <= Disable_;
                rr_ptr <= '0;
            end else if (grant_valid) begin
                wb_e_q <= Enable_;
                wb_q   <= head[grant_idx];
                rr_ptr <= (grant_idx == LastSrc) ? '0 : grant_idx + 1'b1;
            end else begin
                wb_e_q <= Disable_;
            end
        end
    end

    assign wb_e_         = wb_e_q;
    assign wb_rd         = wb_q.rd;
    assign wb_data       = DATA'(wb_q.data);
    assign wb_exp_       = wb_q.exp_;
    assign wb_exp_code   = wb_q.exp_code;
    assign wb_pred_miss_ = wb_q.pred_miss_;
    assign wb_jump_miss_ = wb_q.jump_miss_;

endmodule
